// File: rtl/regfile_mp.sv
// Multi-port register file: 2 write ports, 3 registered read ports, post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is compiled in with `define REGFILE_MP_WRITE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              we0,
    input  logic [ADDR_W-1:0] windex0,
    input  logic [DATA_W-1:0] win0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] windex1,
    input  logic [DATA_W-1:0] win1,
    input  logic [ADDR_W-1:0] rindex0,
    input  logic [ADDR_W-1:0] rindex1,
    input  logic [ADDR_W-1:0] rindex2,
    output logic [DATA_W-1:0] rout0,
    output logic [DATA_W-1:0] rout1,
    output logic [DATA_W-1:0] rout2
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] store [DEPTH];
    logic              wr0;
    logic              wr1;

    function automatic logic is_zero(input logic [ADDR_W-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Port 0 is suppressed on an index collision so port 1 always wins.
    assign wr0 = we0 && !is_zero(windex0) && !(we1 && (windex1 == windex0));
    assign wr1 = we1 && !is_zero(windex1);

    function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = store[idx];
`ifdef REGFILE_MP_WRITE_BYPASS_EN
        if (wr0 && (windex0 == idx)) v = win0;
        if (wr1 && (windex1 == idx)) v = win1;
`endif
        if (is_zero(idx)) v = '0;
        return v;
    endfunction

    // Storage has no reset so it can map onto RAM; the sweep clears it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                store[clr_cnt] <= '0;
            end else begin
                if (wr0) store[windex0] <= win0;
                if (wr1) store[windex1] <= win1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
            rout0   <= '0;
            rout1   <= '0;
            rout2   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    rout0   <= '0;
                    rout1   <= '0;
                    rout2   <= '0;
                    if (clr_cnt == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    rout0 <= rd_sel(rindex0);
                    rout1 <= rd_sel(rindex1);
                    rout2 <= rd_sel(rindex2);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (default parameters) against a behavioural array model.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic          we0, we1;
    logic [AW-1:0] windex0, windex1;
    logic [DW-1:0] win0, win1;
    logic [AW-1:0] rindex0, rindex1, rindex2;
    logic [DW-1:0] rout0, rout1, rout2;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .ready(ready),
        .we0(we0), .windex0(windex0), .win0(win0),
        .we1(we1), .windex1(windex1), .win1(win1),
        .rindex0(rindex0), .rindex1(rindex1), .rindex2(rindex2),
        .rout0(rout0), .rout1(rout1), .rout2(rout2)
    );

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] mem [DEPTH];
    bit            mdl_ready = 1'b0;
    int            sweep = 0;
    logic [DW-1:0] exp_r [3];
    logic          exp_ready;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] obs [3];

    always_comb begin
        obs[0] = rout0;
        obs[1] = rout1;
        obs[2] = rout2;
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
        if (idx == 0) return '0;
`ifdef REGFILE_MP_WRITE_BYPASS_EN
        if (we1 && windex1 == idx) return win1;
        if (we0 && windex0 == idx) return win0;
`endif
        return mem[idx];
    endfunction

    // Predict outputs from the current inputs, advance the model, then step one clock.
    task automatic cycle();
        logic [AW-1:0] ri [3];
        ri[0] = rindex0; ri[1] = rindex1; ri[2] = rindex2;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
            mdl_ready = 1'b0;
            sweep = 0;
            for (int n = 0; n < 3; n++) exp_r[n] = '0;
        end else if (!mdl_ready) begin
            for (int n = 0; n < 3; n++) exp_r[n] = '0;
            sweep++;
            if (sweep == DEPTH) mdl_ready = 1'b1;
        end else begin
            for (int n = 0; n < 3; n++) exp_r[n] = model_read(ri[n]);
            if (we0 && windex0 != 0) mem[windex0] = win0;
            if (we1 && windex1 != 0) mem[windex1] = win1;
        end
        exp_ready = mdl_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
    endtask

    task automatic rand_inputs(input bit writes);
        we0 = writes ? 1'($urandom_range(0, 1)) : 1'b0;
        we1 = writes ? 1'($urandom_range(0, 1)) : 1'b0;
        windex0 = AW'($urandom_range(0, 7));
        windex1 = AW'($urandom_range(0, 7));
        win0 = $urandom;
        win1 = $urandom;
        rindex0 = AW'($urandom_range(0, 7));
        rindex1 = AW'($urandom_range(0, 7));
        rindex2 = AW'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        idle();
        repeat (2) begin
            cycle();
            total++;
            if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
            for (int n = 0; n < 3; n++) begin
                total++;
                if (obs[n] !== '0) begin bad++; $display("FAIL reset_rout%0d got=%h want=0", n, obs[n]); end
            end
        end
        rst = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            rand_inputs(1'b1);
            windex0 = AW'($urandom_range(1, 31));
            we0 = 1'b1;
            cycle();
            cnt++;
            total++;
            if (ready !== exp_ready) begin bad++; $display("FAIL sweep_ready cyc=%0d got=%b want=%b", cnt, ready, exp_ready); end
            for (int n = 0; n < 3; n++) begin
                total++;
                if (obs[n] !== '0) begin bad++; $display("FAIL sweep_rout%0d got=%h want=0", n, obs[n]); end
            end
            if (ready === 1'b1) break;
        end
        total++;
        if (cnt !== DEPTH) begin bad++; $display("FAIL sweep_len got=%0d want=%0d", cnt, DEPTH); end
        idle();
        for (int b = 0; b < DEPTH; b += 3) begin
            rindex0 = AW'(b);
            rindex1 = AW'((b + 1) % DEPTH);
            rindex2 = AW'((b + 2) % DEPTH);
            cycle();
            for (int n = 0; n < 3; n++) begin
                total++;
                if (obs[n] !== '0) begin bad++; $display("FAIL cleared_entry port=%0d got=%h want=0", n, obs[n]); end
            end
        end
    endtask

    task automatic test_basic();
        we0 = 1'b1; windex0 = 5; win0 = 32'hDEADBEEF;
        cycle();
        idle();
        rindex1 = 5;
        cycle();
        total++;
        if (rout1 !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rw got=%h want=deadbeef", rout1); end
    endtask

    task automatic test_collision();
        we0 = 1'b1; windex0 = 7; win0 = 32'h11;
        we1 = 1'b1; windex1 = 7; win1 = 32'h22;
        cycle();
        idle();
        rindex0 = 7;
        cycle();
        total++;
        if (rout0 !== 32'h22) begin bad++; $display("FAIL collision got=%h want=22", rout0); end
    endtask

    task automatic test_zero_reg();
        we1 = 1'b1; windex1 = 0; win1 = 32'hFFFFFFFF;
        rindex2 = 0;
        cycle();
        total++;
        if (rout2 !== '0) begin bad++; $display("FAIL zero_same_cycle got=%h want=0", rout2); end
        idle();
        rindex0 = 0; rindex1 = 0; rindex2 = 0;
        cycle();
        for (int n = 0; n < 3; n++) begin
            total++;
            if (obs[n] !== '0) begin bad++; $display("FAIL zero_reg port=%0d got=%h want=0", n, obs[n]); end
        end
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] want;
        we0 = 1'b1; windex0 = 9; win0 = 32'hA;
        cycle();
        we0 = 1'b0;
        we1 = 1'b1; windex1 = 9; win1 = 32'hB;
        rindex2 = 9;
        cycle();
`ifdef REGFILE_MP_WRITE_BYPASS_EN
        want = 32'hB;
`else
        want = 32'hA;
`endif
        total++;
        if (rout2 !== want) begin bad++; $display("FAIL same_cycle got=%h want=%h", rout2, want); end
        idle();
        cycle();
        total++;
        if (rout2 !== 32'hB) begin bad++; $display("FAIL same_cycle_next got=%h want=b", rout2); end
    endtask

    task automatic test_random();
        logic [DW-1:0] e;
        for (int c = 0; c < 400; c++) begin
            rand_inputs(1'b1);
            cycle();
            for (int n = 0; n < 3; n++) exp_q.push_back(exp_r[n]);
            total++;
            if (ready !== 1'b1) begin bad++; $display("FAIL random_ready cyc=%0d got=%b want=1", c, ready); end
            for (int n = 0; n < 3; n++) begin
                e = exp_q.pop_front();
                total++;
                if (obs[n] !== e) begin bad++; $display("FAIL random_rout%0d cyc=%0d got=%h want=%h", n, c, obs[n], e); end
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        int cnt;
        we0 = 1'b1; windex0 = 3; win0 = 32'h55;
        cycle();
        idle();
        rindex0 = 3;
        cycle();
        total++;
        if (rout0 !== 32'h55) begin bad++; $display("FAIL mid_pre got=%h want=55", rout0); end
        rst = 1'b1;
        cycle();
        total++;
        if (ready !== 1'b0 || rout0 !== '0) begin bad++; $display("FAIL mid_rst ready=%b rout0=%h want 0/0", ready, rout0); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            we0 = 1'b1; windex0 = 3; win0 = 32'h77;
            cycle();
            total++;
            if (ready !== 1'b0) begin bad++; $display("FAIL mid_sweep_ready cyc=%0d got=%b want=0", c, ready); end
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cnt = 0;
        while (cnt < 100) begin
            we0 = 1'b1; windex0 = 3; win0 = 32'h99;
            we1 = 1'b1; windex1 = AW'($urandom_range(1, 31)); win1 = $urandom;
            cycle();
            cnt++;
            if (ready === 1'b1) break;
        end
        total++;
        if (cnt !== DEPTH) begin bad++; $display("FAIL mid_sweep_len got=%0d want=%0d", cnt, DEPTH); end
        idle();
        rindex0 = 3;
        rindex1 = AW'($urandom_range(1, 31));
        rindex2 = 5;
        cycle();
        total++;
        if (rout0 !== '0) begin bad++; $display("FAIL mid_entry3 got=%h want=0", rout0); end
        for (int n = 1; n < 3; n++) begin
            total++;
            if (obs[n] !== exp_r[n]) begin bad++; $display("FAIL mid_cleared port=%0d got=%h want=%h", n, obs[n], exp_r[n]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        windex0 = '0; windex1 = '0; win0 = '0; win1 = '0;
        rindex0 = '0; rindex1 = '0; rindex2 = '0;
        test_reset();
        test_basic();
        test_collision();
        test_zero_reg();
        test_same_cycle();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
